control_unit: RTL and testbench

Execute/control stage of the 8-bit teaching CPU, directly downstream of the instruction memory/PC block. Each cycle it consumes the 8-bit `instruction` word, decodes a 4-bit opcode and 4-bit immediate, updates an 8-bit accumulator, flags and a loop counter, and drives `branch`/`branchaddress` back into the memory block's PC. A three-state FSM squashes the single wrong-path instruction that follows every taken branch and implements halt.

---
 rtl/ctrl_pkg.sv | 25 ++
 rtl/ctrl_alu.sv | 54 +++++
 rtl/control_unit.sv | 133 +++++++++++++
 tb/tb_control_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the teaching-CPU execute/control stage: widths, opcodes, FSM states.
package ctrl_pkg;

  localparam int unsigned DataW = 8;
  localparam int unsigned AddrW = 4;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADDI = 4'h2;
  localparam logic [3:0] OP_SUBI = 4'h3;
  localparam logic [3:0] OP_ANDI = 4'h4;
  localparam logic [3:0] OP_LDC  = 4'h5;
  localparam logic [3:0] OP_DJNZ = 4'h6;
  localparam logic [3:0] OP_JMP  = 4'h7;
  localparam logic [3:0] OP_JZ   = 4'h8;
  localparam logic [3:0] OP_JC   = 4'h9;
  localparam logic [3:0] OP_HLT  = 4'hF;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    HALT  = 2'd2
  } state_e;

endpackage

// File: rtl/ctrl_alu.sv
// Combinational accumulator datapath: computes next acc/Z/C and their write enables.
module ctrl_alu
  import ctrl_pkg::*;
(
  input  logic [DataW-1:0] acc_i,
  input  logic [3:0]       imm_i,
  input  logic [3:0]       op_i,
  output logic [DataW-1:0] acc_o,
  output logic             z_o,
  output logic             c_o,
  output logic             we_o,
  output logic             c_we_o
);

  logic [DataW-1:0] imm_ext;
  logic [DataW:0]   sum;

  assign imm_ext = {4'h0, imm_i};
  assign sum     = {1'b0, acc_i} + {1'b0, imm_ext};

  always_comb begin
    acc_o  = acc_i;
    c_o    = 1'b0;
    we_o   = 1'b0;
    c_we_o = 1'b0;
    case (op_i)
      OP_LDI: begin
        acc_o  = imm_ext;
        we_o   = 1'b1;
        c_we_o = 1'b1;
      end
      OP_ADDI: begin
        acc_o  = sum[DataW-1:0];
        c_o    = sum[DataW];
        we_o   = 1'b1;
        c_we_o = 1'b1;
      end
      OP_SUBI: begin
        acc_o  = acc_i - imm_ext;
        c_o    = imm_ext > acc_i;
        we_o   = 1'b1;
        c_we_o = 1'b1;
      end
      // ANDI leaves carry untouched, so only the acc/Z enable is raised.
      OP_ANDI: begin
        acc_o = acc_i & imm_ext;
        we_o  = 1'b1;
      end
      default: ;
    endcase
    z_o = (acc_o == '0);
  end

endmodule

// File: rtl/control_unit.sv
// Execute/control stage: decode, accumulator/flag update, branch generation and RUN/FLUSH/HALT FSM.
// Define CTRL_LOOP_EN to build the LDC/DJNZ loop counter; otherwise those opcodes act as NOP.
module control_unit
  import ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [DataW-1:0] instruction,
  output logic             branch,
  output logic [AddrW-1:0] branchaddress,
  output logic [DataW-1:0] acc,
  output logic             zflag,
  output logic             cflag,
  output logic             halted
);

  state_e           state_q, state_d;
  logic [DataW-1:0] acc_q, acc_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             branch_q, branch_d;
  logic [AddrW-1:0] baddr_q, baddr_d;
  logic             halted_q, halted_d;
  logic             taken;

  logic [3:0] opcode;
  logic [3:0] imm;

  logic [DataW-1:0] alu_acc;
  logic             alu_z, alu_c, alu_we, alu_c_we;

`ifdef CTRL_LOOP_EN
  logic [3:0] cnt_q, cnt_d, cnt_dec;
  assign cnt_dec = cnt_q - 4'd1;
`endif

  assign opcode = instruction[7:4];
  assign imm    = instruction[3:0];

  ctrl_alu u_alu (
    .acc_i  (acc_q),
    .imm_i  (imm),
    .op_i   (opcode),
    .acc_o  (alu_acc),
    .z_o    (alu_z),
    .c_o    (alu_c),
    .we_o   (alu_we),
    .c_we_o (alu_c_we)
  );

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    z_d      = z_q;
    c_d      = c_q;
    branch_d = 1'b0;
    baddr_d  = baddr_q;
    halted_d = halted_q;
    taken    = 1'b0;
`ifdef CTRL_LOOP_EN
    cnt_d    = cnt_q;
`endif
    case (state_q)
      RUN: begin
        if (alu_we) begin
          acc_d = alu_acc;
          z_d   = alu_z;
        end
        if (alu_c_we) c_d = alu_c;
        case (opcode)
`ifdef CTRL_LOOP_EN
          OP_LDC:  cnt_d = imm;
          OP_DJNZ: begin
            cnt_d = cnt_dec;
            taken = (cnt_dec != 4'd0);
          end
`endif
          OP_JMP: taken = 1'b1;
          OP_JZ:  taken = z_q;
          OP_JC:  taken = c_q;
          OP_HLT: begin
            state_d  = HALT;
            halted_d = 1'b1;
          end
          default: ;
        endcase
        if (taken) begin
          branch_d = 1'b1;
          baddr_d  = imm;
          state_d  = FLUSH;
        end
      end
      // The word fetched after a taken branch is the wrong path; drop it.
      FLUSH:   state_d = RUN;
      HALT:    state_d = HALT;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RUN;
      acc_q    <= '0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
      branch_q <= 1'b0;
      baddr_q  <= '0;
      halted_q <= 1'b0;
`ifdef CTRL_LOOP_EN
      cnt_q    <= 4'd0;
`endif
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      z_q      <= z_d;
      c_q      <= c_d;
      branch_q <= branch_d;
      baddr_q  <= baddr_d;
      halted_q <= halted_d;
`ifdef CTRL_LOOP_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign branch        = branch_q;
  assign branchaddress = baddr_q;
  assign acc           = acc_q;
  assign zflag         = z_q;
  assign cflag         = c_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: a program interpreter predicts per-cycle outputs.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] instruction;
  logic       branch;
  logic [3:0] branchaddress;
  logic [7:0] acc;
  logic       zflag, cflag, halted;

  logic [7:0] rom [16];
  logic [3:0] pc;

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_en = 1'b0;

  // {acc, z, c, branch, branchaddress, halted}
  logic [15:0] exp_q [$];

  control_unit dut (
    .clk           (clk),
    .rst           (rst),
    .instruction   (instruction),
    .branch        (branch),
    .branchaddress (branchaddress),
    .acc           (acc),
    .zflag         (zflag),
    .cflag         (cflag),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  // Instruction memory with the PC contract of the upstream block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         pc <= 4'd0;
    else if (branch) pc <= branchaddress;
    else             pc <= pc + 4'd1;
  end
  assign instruction = rom[pc];

  function automatic logic [15:0] actual_vec();
    return {acc, zflag, cflag, branch, branchaddress, halted};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got acc=%h z=%b c=%b br=%b ba=%h h=%b, want acc=%h z=%b c=%b br=%b ba=%h h=%b",
               name, got[15:8], got[7], got[6], got[5], got[4:1], got[0],
               want[15:8], want[7], want[6], want[5], want[4:1], want[0]);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (mon_en && exp_q.size() > 0) check("trace", actual_vec(), exp_q.pop_front());
  end

  function automatic logic [7:0] ins(input int op, input int imm);
    return 8'((op << 4) | (imm & 15));
  endfunction

  // Reference: interpret the ROM program, one entry per clock edge after reset release.
  task automatic model_push(input int ncyc);
    int  pcm = 0, a = 0, cnt = 0, ba = 0, op, im, s;
    bit  z = 0, c = 0, br = 0, h = 0, fl = 0, tk;
    bit  loop_en;
`ifdef CTRL_LOOP_EN
    loop_en = 1'b1;
`else
    loop_en = 1'b0;
`endif
    for (int i = 0; i < ncyc; i++) begin
      if (h) begin
        br = 0;
      end else if (fl) begin
        fl = 0;
        br = 0;
        pcm = ba;
      end else begin
        op = int'(rom[pcm][7:4]);
        im = int'(rom[pcm][3:0]);
        tk = 0;
        case (op)
          1: begin a = im; z = (a == 0); c = 0; end
          2: begin s = a + im; c = (s > 255); a = s % 256; z = (a == 0); end
          3: begin c = (im > a); a = (a - im + 256) % 256; z = (a == 0); end
          4: begin a = a & im; z = (a == 0); end
          5: if (loop_en) cnt = im;
          6: if (loop_en) begin cnt = (cnt + 15) % 16; tk = (cnt != 0); end
          7: tk = 1;
          8: tk = z;
          9: tk = c;
          15: h = 1;
          default: ;
        endcase
        br = tk;
        if (tk) begin
          ba = im;
          fl = 1;
        end else begin
          pcm = (pcm + 1) % 16;
        end
      end
      exp_q.push_back({8'(a), z, c, br, 4'(ba), h});
    end
  endtask

  // Expects rst high on entry; leaves rst high on exit.
  task automatic run_prog(input int ncyc);
    model_push(ncyc);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < ncyc + 4 && exp_q.size() > 0; k++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: got %0d entries left, want 0", exp_q.size());
      exp_q.delete();
    end
    mon_en = 1'b0;
    rst    = 1'b1;
    #1;
  endtask

  task automatic fill_rom(input logic [7:0] w);
    for (int i = 0; i < 16; i++) rom[i] = w;
  endtask

  initial begin
    fill_rom(ins(2, 1));
    #2 rst = 1'b1;
    #1 check("reset_state", actual_vec(), 16'h0000);
    repeat (2) @(negedge clk);

    // Basic arithmetic then halt; trailing ADDI 1 must never run.
    fill_rom(ins(2, 1));
    rom[0] = ins(1, 3); rom[1] = ins(2, 5); rom[2] = ins(3, 8); rom[3] = ins(15, 0);
    run_prog(8);

    // Borrow and carry paths.
    fill_rom(ins(0, 0));
    rom[0] = ins(1, 0); rom[1] = ins(3, 2); rom[2] = ins(2, 3); rom[3] = ins(3, 2);
    rom[4] = ins(4, 15); rom[5] = ins(15, 0);
    run_prog(8);

    // JMP 2 at address 5; address 6 lies in the squash slot.
    fill_rom(ins(0, 0));
    rom[0] = ins(1, 0); rom[2] = ins(2, 2); rom[5] = ins(7, 2); rom[6] = ins(2, 1);
    run_prog(16);

    // JZ not taken, then taken with HLT in the flush slot.
    fill_rom(ins(0, 0));
    rom[0] = ins(1, 1); rom[1] = ins(8, 7); rom[2] = ins(3, 1); rom[3] = ins(8, 6);
    rom[4] = ins(15, 0); rom[5] = ins(2, 9); rom[6] = ins(2, 4); rom[7] = ins(15, 0);
    rom[8] = ins(9, 0);
    run_prog(12);

    // Counted loop (straight-line when the counter is not built).
    fill_rom(ins(0, 0));
    rom[0] = ins(1, 0); rom[1] = ins(5, 3); rom[2] = ins(2, 1); rom[3] = ins(6, 2);
    rom[4] = ins(9, 8); rom[5] = ins(15, 0); rom[8] = ins(2, 7); rom[9] = ins(15, 0);
    run_prog(16);

    // Reset while in FLUSH with branch high.
    fill_rom(ins(0, 0));
    rom[0] = ins(7, 5); rom[1] = ins(15, 0); rom[5] = ins(2, 7); rom[6] = ins(15, 0);
    model_push(1);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    mon_en = 1'b0;
    rst    = 1'b1;
    #1 check("async_reset_in_flush", actual_vec(), 16'h0000);
    exp_q.delete();
    run_prog(6);

    // Random programs; HLT is thinned out so most runs stay busy.
    for (int t = 0; t < 24; t++) begin
      for (int i = 0; i < 16; i++) begin
        logic [7:0] w;
        w = 8'($urandom);
        if (w[7:4] == 4'hF && $urandom_range(3) != 0) w[7:4] = 4'h2;
        rom[i] = w;
      end
      run_prog(40);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
